aes_key_schedule: RTL and testbench

//  Parametrised AES key expansion for AES-128/192/256, mode chosen per key load.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_key_schedule_if.sv | 26 ++
 rtl/aes_key_schedule_sbox.sv | 29 ++
 rtl/aes_key_schedule.sv | 149 ++++++++++++++
 tb/tb_aes_key_schedule.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, sizes and small arithmetic helpers.
package aes_pkg;

    localparam int unsigned KEY_W     = 256;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned NUM_WORDS = 60;
    localparam int unsigned WIDX_W    = 6;

    typedef enum logic [1:0] {
        AES128  = 2'b00,
        AES192  = 2'b01,
        AES256  = 2'b10,
        AES_ILL = 2'b11
    } aes_mode_t;

    typedef logic [31:0] aes_word_t;

    function automatic logic [3:0] nk_of(input aes_mode_t m);
        case (m)
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_t m);
        case (m)
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load, status and round-key read bus of the AES key schedule.
interface aes_key_schedule_if;

    logic                       key_load;
    logic [1:0]                 key_mode;
    logic [aes_pkg::KEY_W-1:0]  key_in;
    logic                       busy;
    logic                       keys_rdy;
    logic                       cfg_err;
    logic                       rd_en;
    logic [3:0]                 rd_round;
    logic                       rd_valid;
    logic                       rd_err;
    logic [aes_pkg::BLK_W-1:0]  rd_key;

    modport slave (
        input  key_load, key_mode, key_in, rd_en, rd_round,
        output busy, keys_rdy, cfg_err, rd_valid, rd_err, rd_key
    );

    modport master (
        output key_load, key_mode, key_in, rd_en, rd_round,
        input  busy, keys_rdy, cfg_err, rd_valid, rd_err, rd_key
    );

endinterface

// File: rtl/aes_key_schedule_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_key_schedule_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout_c
);

    // Byte 0 sits in the top bits, so entry a lives at bit offset 8*(255-a) = {~a,3'b0}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout_c = SBOX_TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion into a random-access round-key store.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter bit EN_192 = 1'b1,
    parameter bit EN_256 = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    aes_key_schedule_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

    state_t             state_q, state_d;
    aes_mode_t          mode_q, in_mode;
    logic [KEY_W-1:0]   key_q;
    logic [KEY_W-1:0]   win_q;
    aes_word_t          store [NUM_WORDS];
    logic [WIDX_W-1:0]  i_q;
    logic [2:0]         pos_q;
    logic [7:0]         rcon_q;
    logic               busy_q, keys_rdy_q, cfg_err_q, rd_valid_q, rd_err_q;
    logic [BLK_W-1:0]   rd_key_q;
    logic               busy_d, keys_rdy_d;
    logic               mode_ok_c, legal_load_c, rd_ok_c;
    logic [3:0]         nk_c, nr_c;
    logic [WIDX_W-1:0]  last_idx_c, base_c;
    aes_word_t          newest_c, back_c, sub_in_c, sub_out_c, temp_c, new_word_c;

    assign in_mode      = aes_mode_t'(bus.key_mode);
    assign nk_c         = nk_of(mode_q);
    assign nr_c         = nr_of(mode_q);
    assign last_idx_c   = {nr_c, 2'b11};
    assign legal_load_c = bus.key_load && mode_ok_c;

    always_comb begin
        mode_ok_c = 1'b0;
        case (in_mode)
            AES128:  mode_ok_c = 1'b1;
            AES192:  mode_ok_c = EN_192;
            AES256:  mode_ok_c = EN_256;
            default: mode_ok_c = 1'b0;
        endcase
    end

    // Next state and registered status outputs; a legal load overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = S_EXPAND;
            S_EXPAND: if (i_q == last_idx_c) state_d = S_DONE;
            default:  state_d = state_q;
        endcase
        if (legal_load_c) state_d = S_LOAD;
        busy_d     = (state_d == S_LOAD) || (state_d == S_EXPAND);
        keys_rdy_d = (state_d == S_DONE);
    end

    // Window: win_q[31:0] = w[i-1] ... win_q[255:224] = w[i-8].
    assign newest_c = win_q[31:0];
    assign sub_in_c = (pos_q == 3'd0) ? {newest_c[23:0], newest_c[31:24]} : newest_c;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_key_schedule_sbox u_sbox (
            .din    (sub_in_c[8*b +: 8]),
            .dout_c (sub_out_c[8*b +: 8])
        );
    end

    always_comb begin
        case (mode_q)
            AES192:  back_c = win_q[191:160];
            AES256:  back_c = win_q[255:224];
            default: back_c = win_q[127:96];
        endcase
        if (pos_q == 3'd0)
            temp_c = sub_out_c ^ {rcon_q, 24'h0};
        else if (mode_q == AES256 && pos_q == 3'd4)
            temp_c = sub_out_c;
        else
            temp_c = newest_c;
        new_word_c = back_c ^ temp_c;
    end

    assign base_c  = {bus.rd_round, 2'b00};
    assign rd_ok_c = bus.rd_en && !legal_load_c && (bus.rd_round <= nr_c)
                     && (({1'b0, base_c} + 7'd3) < {1'b0, i_q});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            keys_rdy_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            mode_q     <= AES128;
            key_q      <= '0;
            i_q        <= '0;
            pos_q      <= '0;
            rcon_q     <= 8'h01;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            keys_rdy_q <= keys_rdy_d;
            cfg_err_q  <= bus.key_load && !mode_ok_c;
            if (legal_load_c) begin
                mode_q <= in_mode;
                key_q  <= bus.key_in;
                i_q    <= '0;
            end else if (state_q == S_LOAD) begin
                i_q    <= WIDX_W'(nk_c);
                pos_q  <= '0;
                rcon_q <= 8'h01;
            end else if (state_q == S_EXPAND) begin
                i_q   <= i_q + 6'd1;
                pos_q <= (pos_q == 3'(nk_c - 4'd1)) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
            rd_valid_q <= rd_ok_c;
            rd_err_q   <= bus.rd_en && !rd_ok_c;
            if (rd_ok_c)
                rd_key_q <= {store[base_c], store[base_c + 6'd1],
                             store[base_c + 6'd2], store[base_c + 6'd3]};
        end
    end

    // Word store and window carry no reset; i_q alone decides what is readable.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            win_q <= key_q >> (32 * (8 - int'(nk_c)));
            for (int j = 0; j < 8; j++)
                if (j < int'(nk_c)) store[6'(j)] <= key_q[8'(255 - 32 * j) -: 32];
        end else if (state_q == S_EXPAND) begin
            win_q      <= {win_q[223:0], new_word_c};
            store[i_q] <= new_word_c;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.keys_rdy = keys_rdy_q;
    assign bus.cfg_err  = cfg_err_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_key   = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    aes_key_schedule_if bus ();
    aes_key_schedule_if bus2 ();

    aes_key_schedule #(.EN_192(1'b1), .EN_256(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );
    aes_key_schedule #(.EN_192(1'b1), .EN_256(1'b0)) dut_n256 (
        .clk(clk), .n_rst(n_rst), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Unused low key bits carry junk that must be ignored.
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h5555aaaa_3333cccc};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input bit sel, input logic [1:0] mode, input logic [255:0] key, output int t0);
        @(negedge clk);
        if (sel) begin bus2.key_load = 1'b1; bus2.key_mode = mode; bus2.key_in = key; end
        else     begin bus.key_load  = 1'b1; bus.key_mode  = mode; bus.key_in  = key; end
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.key_load  = 1'b0;
        bus2.key_load = 1'b0;
    endtask

    // Returns cycles from the key_load edge (counted as 1) to keys_rdy, or -1 on timeout.
    task automatic wait_rdy(input bit sel, input int t0, output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if ((sel ? bus2.keys_rdy : bus.keys_rdy) === 1'b1) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
    endtask

    task automatic rd(input logic [3:0] r, output logic v, output logic e, output logic [127:0] k);
        @(negedge clk);
        bus.rd_en    = 1'b1;
        bus.rd_round = r;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        v = bus.rd_valid;
        e = bus.rd_err;
        k = bus.rd_key;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat;
        logic v, e;
        logic [127:0] k;

        bus.key_load = 1'b0;  bus.key_mode = 2'b00;  bus.key_in = '0;
        bus.rd_en = 1'b0;     bus.rd_round = 4'd0;
        bus2.key_load = 1'b0; bus2.key_mode = 2'b00; bus2.key_in = '0;
        bus2.rd_en = 1'b0;    bus2.rd_round = 4'd0;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_keys_rdy", bus.keys_rdy, 1'b0);
        chk1("rst_cfg_err", bus.cfg_err, 1'b0);
        chk1("rst_rd_valid", bus.rd_valid, 1'b0);
        chk1("rst_rd_err", bus.rd_err, 1'b0);
        chk("rst_rd_key", bus.rd_key, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // AES-128 latency and endpoints
        load(1'b0, 2'b00, K128, t0);
        chk1("load_busy", bus.busy, 1'b1);
        wait_rdy(1'b0, t0, lat);
        chki("lat128", lat, 42);
        chk1("done_busy", bus.busy, 1'b0);
        rd(4'd1, v, e, k);
        chk("aes128_r1", k, RK[1]);
        rd(4'd10, v, e, k);
        chk("aes128_r10", k, RK[10]);
        chk1("aes128_r10_valid", v, 1'b1);

        // AES-192
        load(1'b0, 2'b01, K192, t0);
        wait_rdy(1'b0, t0, lat);
        chki("lat192", lat, 48);
        rd(4'd12, v, e, k);
        chk("aes192_r12", k, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13, v, e, k);
        chk1("aes192_r13_err", e, 1'b1);

        // AES-256
        load(1'b0, 2'b10, K256, t0);
        wait_rdy(1'b0, t0, lat);
        chki("lat256", lat, 54);
        rd(4'd14, v, e, k);
        chk("aes256_r14", k, 128'hfe4890d1e6188d0b046df344706c631e);
        chk1("aes256_r14_valid", v, 1'b1);
        rd(4'd15, v, e, k);
        chk1("aes256_r15_err", e, 1'b1);

        // Early and out-of-range reads
        load(1'b0, 2'b00, K128, t0);
        @(posedge clk);
        rd(4'd0, v, e, k);
        chk1("early_r0_valid", v, 1'b1);
        chk("early_r0_key", k, RK[0]);
        rd(4'd10, v, e, k);
        chk1("early_r10_err", e, 1'b1);
        chk1("early_r10_valid", v, 1'b0);
        chk("early_r10_hold", k, RK[0]);
        @(posedge clk);
        #1;
        chk1("idle_rd_valid", bus.rd_valid, 1'b0);
        chk1("idle_rd_err", bus.rd_err, 1'b0);
        wait_rdy(1'b0, t0, lat);
        chki("lat128_reads", lat, 42);
        rd(4'd11, v, e, k);
        chk1("r11_err", e, 1'b1);
        chk1("r11_valid", v, 1'b0);
        for (int r = 10; r >= 0; r--) begin
            rd(4'(r), v, e, k);
            chk1($sformatf("desc_valid%0d", r), v, 1'b1);
            chk($sformatf("desc_key%0d", r), k, RK[r]);
        end

        // Read colliding with a legal key_load
        @(negedge clk);
        bus.key_load = 1'b1; bus.key_mode = 2'b00; bus.key_in = K128;
        bus.rd_en = 1'b1;    bus.rd_round = 4'd0;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.key_load = 1'b0; bus.rd_en = 1'b0;
        chk1("collide_err", bus.rd_err, 1'b1);
        chk1("collide_valid", bus.rd_valid, 1'b0);
        chk1("collide_rdy_drop", bus.keys_rdy, 1'b0);
        wait_rdy(1'b0, t0, lat);
        chki("lat128_collide", lat, 42);

        // Abort AES-256 with AES-128
        load(1'b0, 2'b10, K256, t0);
        repeat (20) @(posedge clk);
        load(1'b0, 2'b00, K128, t0);
        wait_rdy(1'b0, t0, lat);
        chki("lat_abort", lat, 42);
        rd(4'd1, v, e, k);
        chk("abort_r1", k, RK[1]);
        rd(4'd10, v, e, k);
        chk("abort_r10", k, RK[10]);

        // Asynchronous reset mid-expansion
        load(1'b0, 2'b00, K128, t0);
        repeat (10) @(posedge clk);
        #1;
        chk1("mid_busy", bus.busy, 1'b1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk1("arst_busy", bus.busy, 1'b0);
        chk1("arst_keys_rdy", bus.keys_rdy, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        rd(4'd0, v, e, k);
        chk1("post_rst_r0_err", e, 1'b1);

        // Illegal mode 11
        load(1'b0, 2'b00, K128, t0);
        wait_rdy(1'b0, t0, lat);
        chki("lat128_pre_ill", lat, 42);
        @(negedge clk);
        bus.key_load = 1'b1; bus.key_mode = 2'b11; bus.key_in = K256;
        @(posedge clk);
        #1;
        bus.key_load = 1'b0;
        chk1("ill_cfg_err", bus.cfg_err, 1'b1);
        chk1("ill_keys_rdy", bus.keys_rdy, 1'b1);
        chk1("ill_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        chk1("ill_cfg_err_pulse", bus.cfg_err, 1'b0);
        rd(4'd10, v, e, k);
        chk("ill_r10", k, RK[10]);

        // Disabled AES-256 on the EN_256=0 instance
        load(1'b1, 2'b00, K128, t0);
        wait_rdy(1'b1, t0, lat);
        chki("n256_lat128", lat, 42);
        @(negedge clk);
        bus2.key_load = 1'b1; bus2.key_mode = 2'b10; bus2.key_in = K256;
        @(posedge clk);
        #1;
        bus2.key_load = 1'b0;
        chk1("n256_cfg_err", bus2.cfg_err, 1'b1);
        chk1("n256_keys_rdy", bus2.keys_rdy, 1'b1);
        @(negedge clk);
        bus2.rd_en = 1'b1; bus2.rd_round = 4'd10;
        @(posedge clk);
        #1;
        bus2.rd_en = 1'b0;
        chk1("n256_r10_valid", bus2.rd_valid, 1'b1);
        chk("n256_r10", bus2.rd_key, RK[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
